// File: rtl/sram_like_bridge_pkg.sv
// Shared types for the single-cycle-port to SRAM-like bus bridge.
package sram_like_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      DONE      = 2'd2
   } state_e;

   localparam int DEF_DEPTH = 2;
   localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/sram_like_bridge_txn_type_fifo.sv
// In-order record of outstanding bus transaction types (1 = read).
// Its occupancy is the bridge's outstanding-transaction count.
module txn_type_fifo
   import sram_like_bridge_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic pop_i,
   input  logic din_i,
   output logic head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   // A pop on an empty FIFO is a bus protocol error and is dropped.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridges the core's single-cycle data-SRAM port onto a req/addr_ok/data_ok bus,
// posting writes and stalling reads until their own data returns.
module sram_like_bridge
   import sram_like_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_en,
   input  logic [DATA_W/8-1:0] cpu_wen,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic                pipe_stall,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_stall,
   output logic                req,
   output logic                wr,
   output logic [DATA_W/8-1:0] wstrb,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W-1:0]   wdata,
   input  logic                addr_ok,
   input  logic                data_ok,
   input  logic [DATA_W-1:0]   rdata
);

   state_e            state_q;
   state_e            state_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              accept;
   logic              pop;
   logic              head_is_read;
   logic              fifo_full;
   logic              fifo_empty;

   assign wr        = |cpu_wen;
   assign wstrb     = cpu_wen;
   assign addr      = cpu_addr;
   assign wdata     = cpu_wdata;
   assign req       = ~rst & cpu_en & (state_q == IDLE) & ~fifo_full;
   assign accept    = req & addr_ok;
   assign pop       = data_ok & ~fifo_empty;
   // Posted writes release the pipe in their accept cycle; reads wait for DONE.
   assign cpu_stall = ~rst & cpu_en & (state_q != DONE) & ~(accept & wr);
   assign cpu_rdata = rdata_q;

   txn_type_fifo #(
      .DEPTH (DEPTH)
   ) u_type_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .pop_i   (data_ok),
      .din_i   (~wr),
      .head_o  (head_is_read),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (wr) begin
                  state_d = pipe_stall ? DONE : IDLE;
               end else begin
                  state_d = WAIT_DATA;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_DATA: begin
            // Only one read is ever outstanding, so a read at the head is ours.
            if (pop && head_is_read) begin
               rdata_d = rdata;
               state_d = DONE;
            end else begin
               state_d = WAIT_DATA;
            end
         end
         DONE: begin
            if (!pipe_stall) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: the bench plays the bus slave cycle by cycle
// and a queue holds the read data each read is expected to deliver.
module tb_sram_like_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        pipe_stall;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp;

   always #5 clk = ~clk;

   sram_like_bridge #(
      .ADDR_W (32),
      .DATA_W (32),
      .DEPTH  (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_en     (cpu_en),
      .cpu_wen    (cpu_wen),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .pipe_stall (pipe_stall),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .req        (req),
      .wr         (wr),
      .wstrb      (wstrb),
      .addr       (addr),
      .wdata      (wdata),
      .addr_ok    (addr_ok),
      .data_ok    (data_ok),
      .rdata      (rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rdata(input string tag);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, cpu_rdata);
      end else begin
         last_exp = exp_q.pop_front();
         chk(tag, cpu_rdata, last_exp);
      end
   endtask

   task automatic drv(input logic en, input logic [3:0] wen, input logic [31:0] a,
                      input logic [31:0] wd, input logic aok, input logic dok,
                      input logic [31:0] brd, input logic ps);
      cpu_en     = en;
      cpu_wen    = wen;
      cpu_addr   = a;
      cpu_wdata  = wd;
      addr_ok    = aok;
      data_ok    = dok;
      rdata      = brd;
      pipe_stall = ps;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset: outputs quiet even with an access pending.
      rst = 1'b1;
      drv(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("rst_req", req, 1'b0);
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      nxt();
      rst = 1'b0;
      drv(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      nxt();

      // Single read of 0x10, addr_ok cycle 0, data_ok cycle 1.
      drv(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      chk("rd1_c0_req", req, 1'b1);
      chk("rd1_c0_wr", wr, 1'b0);
      chk("rd1_c0_addr", addr, 32'h10);
      chk("rd1_c0_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      chk("rd1_c1_req", req, 1'b0);
      chk("rd1_c1_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("rd1_c2_req", req, 1'b0);
      chk("rd1_c2_stall", cpu_stall, 1'b0);
      chk_rdata("rd1_c2_rdata");
      nxt();

      // Three back-to-back writes; slave holds data_ok low until write 3 is blocked.
      drv(1'b1, 4'hF, 32'h100, 32'hA1, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w1_req", req, 1'b1);
      chk("w1_wstrb", wstrb, 4'hF);
      chk("w1_stall", cpu_stall, 1'b0);
      nxt();
      drv(1'b1, 4'hF, 32'h104, 32'hA2, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w2_wdata", wdata, 32'hA2);
      chk("w2_stall", cpu_stall, 1'b0);
      nxt();
      drv(1'b1, 4'hF, 32'h108, 32'hA3, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w3_full_req", req, 1'b0);
      chk("w3_full_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'hF, 32'h108, 32'hA3, 1'b1, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      chk("w3_dok_req", req, 1'b0);
      chk("w3_dok_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'hF, 32'h108, 32'hA3, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("w3_acc_req", req, 1'b1);
      chk("w3_acc_stall", cpu_stall, 1'b0);
      nxt();
      drv(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      nxt();
      nxt();

      // Write 0x20 then read 0x24; the write's data_ok must not end the stall.
      drv(1'b1, 4'hF, 32'h20, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("wr_rd_w_stall", cpu_stall, 1'b0);
      nxt();
      drv(1'b1, 4'h0, 32'h24, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_q.push_back(32'hCAFEF00D);
      @(negedge clk);
      chk("wr_rd_r_req_cnt1", req, 1'b1);
      chk("wr_rd_r_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h11111111, 1'b0);
      @(negedge clk);
      chk("wr_rd_dok1_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
      @(negedge clk);
      chk("wr_rd_dok2_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("wr_rd_done_stall", cpu_stall, 1'b0);
      chk_rdata("wr_rd_done_rdata");
      nxt();

      // Same-cycle accept and data_ok at cnt=1: count holds, FIFO head advances.
      drv(1'b1, 4'h3, 32'h30, 32'hB1, 1'b1, 1'b0, 32'h0, 1'b0);
      nxt();
      drv(1'b1, 4'hC, 32'h34, 32'hB2, 1'b1, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      chk("same_w2_req", req, 1'b1);
      chk("same_w2_stall", cpu_stall, 1'b0);
      nxt();
      drv(1'b1, 4'h0, 32'h38, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_q.push_back(32'h0BADF00D);
      @(negedge clk);
      chk("same_rd_req_cnt1", req, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h38, 32'h0, 1'b0, 1'b1, 32'h22222222, 1'b0);
      @(negedge clk);
      chk("same_head_w_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h38, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
      @(negedge clk);
      chk("same_head_r_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h38, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("same_done_stall", cpu_stall, 1'b0);
      chk_rdata("same_done_rdata");
      nxt();

      // pipe_stall held through DONE: no re-issue, stable rdata, IDLE after release.
      drv(1'b1, 4'h0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      exp_q.push_back(32'h600DCAFE);
      nxt();
      drv(1'b1, 4'h0, 32'h44, 32'h0, 1'b0, 1'b1, 32'h600DCAFE, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("ps_done0_req", req, 1'b0);
      chk_rdata("ps_done0_rdata");
      for (int i = 1; i < 3; i++) begin
         nxt();
         @(negedge clk);
         chk($sformatf("ps_done%0d_req", i), req, 1'b0);
         chk($sformatf("ps_done%0d_stall", i), cpu_stall, 1'b0);
         chk($sformatf("ps_done%0d_rdata", i), cpu_rdata, last_exp);
      end
      nxt();
      drv(1'b1, 4'h0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("ps_release_req", req, 1'b0);
      chk("ps_release_stall", cpu_stall, 1'b0);
      nxt();
      drv(1'b1, 4'h0, 32'h48, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("ps_idle_req", req, 1'b1);
      chk("ps_idle_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      nxt();

      // Reset in WAIT_DATA with two outstanding, then a stray data_ok and a fresh read.
      drv(1'b1, 4'hF, 32'h50, 32'hC1, 1'b1, 1'b0, 32'h0, 1'b0);
      nxt();
      drv(1'b1, 4'h0, 32'h54, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      nxt();
      rst = 1'b1;
      drv(1'b1, 4'h0, 32'h54, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("rst_mid_req", req, 1'b0);
      chk("rst_mid_stall", cpu_stall, 1'b0);
      nxt();
      rst = 1'b0;
      drv(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      chk("rst_after_rdata", cpu_rdata, 32'h0);
      nxt();
      drv(1'b1, 4'h0, 32'h60, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_q.push_back(32'h12345678);
      @(negedge clk);
      chk("rst_fresh_req", req, 1'b1);
      chk("rst_fresh_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h60, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0);
      @(negedge clk);
      chk("rst_fresh_wait_stall", cpu_stall, 1'b1);
      nxt();
      drv(1'b1, 4'h0, 32'h60, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("rst_fresh_done_stall", cpu_stall, 1'b0);
      chk_rdata("rst_fresh_done_rdata");
      nxt();
      drv(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      nxt();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Converts the CPU core's single-cycle data-SRAM port (en/wen/addr/wdata/rdata) into a split-handshake SRAM-like bus (req/addr_ok/data_ok). It sits between the mem stage and the cache/AXI interface. It generates the pipeline stall the core previously had no source for. Writes are posted, up to DEPTH in flight. A read blocks the pipeline until its own data returns, strictly in order behind earlier posted writes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- DEPTH, 2, maximum outstanding bus transactions; power of 2, ≥1
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cpu_en  in  1  mem-stage access request; held stable with all cpu_* inputs while cpu_stall=1
- cpu_wen  in  DATA_W/8  byte write strobes; 0 means read
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- pipe_stall  in  1  pipeline is frozen for another reason; the mem stage will not advance
- cpu_rdata  out  DATA_W  read data; valid only while the state is DONE
- cpu_stall  out  1  hold the mem stage
- req  out  1  bus request
- wr  out  1  request is a write
- wstrb  out  DATA_W/8  byte strobes, equal to cpu_wen
- addr  out  ADDR_W  equal to cpu_addr
- wdata  out  DATA_W  equal to cpu_wdata
- addr_ok  in  1  request accepted this cycle (only meaningful when req=1)
- data_ok  in  1  oldest outstanding transaction completes; for reads, rdata is valid
- rdata  in  DATA_W  bus read data

## Operation
- State variable: IDLE, WAIT_DATA, DONE.
- Counter cnt, range 0..DEPTH: outstanding transactions.
- Type FIFO, DEPTH×1 bit, 1 = read. It is pushed on every accept and popped on every data_ok.
- accept = req & addr_ok.
- req = cpu_en & (state==IDLE) & (cnt<DEPTH).
- wr = |cpu_wen.
- IDLE, write accepted: the write is posted. Next state is DONE if pipe_stall=1, otherwise IDLE.
- IDLE, read accepted: next state is WAIT_DATA.
- WAIT_DATA: when data_ok=1 and the FIFO head is a read, capture rdata into the cpu_rdata register and go to DONE. data_ok for a head write only pops the FIFO.
- DONE: req=0, so the completed access is never re-issued. Go to IDLE in the first cycle with pipe_stall=0.
- cpu_stall = cpu_en & ~(state==DONE) & ~(accept & wr).
- cnt update: +1 on accept, −1 on data_ok, unchanged when both occur in the same cycle.
- Full (cnt==DEPTH): req is held at 0 and cpu_stall stays 1 until a data_ok frees a slot.
- Once req=1, addr/wdata/wstrb stay stable until addr_ok. This is guaranteed because cpu_stall=1 holds the inputs.
- Bus ordering rule: data_ok for a transaction arrives no earlier than the cycle after its addr_ok. The bridge never asserts req while cnt==DEPTH.
- data_ok while cnt==0 is a protocol error. It is ignored and the counter does not underflow.

## Timing
- Reset values:
  - state=IDLE, cnt=0, FIFO empty, cpu_rdata=0.
  - req=0, and cpu_stall=0 while rst is high.
- Reset mid-transaction drops all outstanding state. The bus slave is reset by the same rst.
- Write, not full: zero-cycle stall when addr_ok comes in the request cycle; cpu_stall=0 in that cycle.
- Read, empty pipe, addr_ok in cycle 0, data_ok in cycle 1:
  - cpu_stall=1 in cycles 0–1.
  - Cycle 2 is DONE with cpu_stall=0 and cpu_rdata valid.
  - Total latency 2 cycles.
- Read behind N posted writes: the read may be accepted while those writes are outstanding. DONE occurs the cycle after the data_ok that pops the read.
- cpu_stall is combinational from cpu_en, cpu_wen, addr_ok and state. No other path is combinational to outputs.

## Structure
- Package sram_like_bridge_pkg holds:
  - the state enum (IDLE, WAIT_DATA, DONE);
  - the localparam CNT_W = $clog2(DEPTH+1).
- Sub-module txn_type_fifo: parameterised DEPTH×1 FIFO with push, pop, head, and full/empty flags. Simultaneous push and pop is legal when full or empty+push.
- The bridge is instantiated in the CPU top between the datapath mem stage and the external data port. Its cpu_stall is ORed into the existing stallM source.

## Test plan
- Single read, addr 0x0000_0010, slave returns 0xDEADBEEF:
  - addr_ok in cycle 0, data_ok in cycle 1.
  - Required: cpu_stall=1,1,0; cpu_rdata=0xDEADBEEF in cycle 2; req high only in cycle 0.
- Three back-to-back writes (wen=4'hF), DEPTH=2, slave holds data_ok low:
  - Writes 1 and 2 are accepted with zero stall.
  - Write 3 sees req=0 and cpu_stall=1 until the first data_ok, then is accepted the next cycle.
- Write to 0x20, then read of 0x24, with data_ok returned in order:
  - The read is accepted while cnt=1.
  - The first data_ok (the write's) does not end the stall.
  - The second data_ok delivers rdata; DONE follows next cycle.
- Same-cycle accept and data_ok at cnt=1: cnt stays 1; FIFO head advances correctly (check with an assertion).
- pipe_stall held high 3 cycles during DONE:
  - req stays 0 throughout, so there is no duplicate transaction.
  - cpu_rdata is stable; IDLE is entered the cycle after pipe_stall falls.
- rst asserted in WAIT_DATA with cnt=2: next cycle state=IDLE, cnt=0, req=0, cpu_stall=0; a fresh read completes normally afterwards.
